ibex_bus_arb: RTL and testbench
===============================

# ibex_bus_arb

Two-host to one-device bus arbiter for a single-port memory system. It merges the core's instruction-fetch and data interfaces onto one shared memory port using the same req/gnt/rvalid protocol. It tracks in-flight transactions so each response, including data, integrity and error, returns to the host that issued it. It sits between `ibex_top` and the memory or interconnect, and adds zero cycles of latency.

## Interface
- `MaxOutstanding`, default 2: depth of the response-routing ID queue, in range 1–4.
- `DataPriority`, default 1'b1: when 1, data wins a simultaneous request; when 0, arbitration is round-robin.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `instr_req_i`  in  1. `instr_addr_i`  in  32.
- `instr_gnt_o`  out  1. `instr_rvalid_o`  out  1. `instr_rdata_o`  out  32. `instr_rdata_intg_o`  out  7. `instr_err_o`  out  1.
- `data_req_i`  in  1. `data_we_i`  in  1. `data_be_i`  in  4. `data_addr_i`  in  32. `data_wdata_i`  in  32. `data_wdata_intg_i`  in  7.
- `data_gnt_o`  out  1. `data_rvalid_o`  out  1. `data_rdata_o`  out  32. `data_rdata_intg_o`  out  7. `data_err_o`  out  1.
- `mem_req_o`  out  1. `mem_we_o`  out  1. `mem_be_o`  out  4. `mem_addr_o`  out  32. `mem_wdata_o`  out  32. `mem_wdata_intg_o`  out  7.
- `mem_gnt_i`  in  1. `mem_rvalid_i`  in  1. `mem_rdata_i`  in  32. `mem_rdata_intg_i`  in  7. `mem_err_i`  in  1.
- `busy_o`  out  1: the ID queue is non-empty.
- `protocol_err_o`  out  1: one-cycle pulse when `mem_rvalid_i` arrives with the queue empty.

## Operation
- Selection runs as a state machine with states `IDLE`, `LOCK_INSTR` and `LOCK_DATA`.
  - In `IDLE`, the winner is chosen combinationally: by priority, or by the round-robin pointer (last granted source loses a tie).
  - If `mem_req_o` is high and `mem_gnt_i` is low, the FSM enters `LOCK_<winner>` and holds that selection until the grant. Request and payload stay stable, as the protocol requires.
  - A grant returns the FSM to `IDLE`.
  - The round-robin pointer updates only on a grant.
- Forwarding:
  - `mem_req_o` = selected host req & ~queue_full.
  - The payload comes from the selected host.
  - Instruction fetches drive `we`=0, `be`=4'hF, `wdata`=0 and `wdata_intg`=`IbexZeroWordIntg`.
- Grant: `<host>_gnt_o` = `mem_gnt_i` & `mem_req_o` & selected(host).
- ID queue (FIFO of source IDs):
  - Push the selected source on `mem_req_o & mem_gnt_i`.
  - Pop on `mem_rvalid_i`.
  - When the queue is full, `mem_req_o` is held low, even if a pop happens in the same cycle. There is no bypass.
  - A push and pop in the same cycle while not full keeps the count unchanged.
- Response routing:
  - `<host>_rvalid_o` = `mem_rvalid_i` & (queue head == host) & ~empty.
  - `rdata`, `rdata_intg` and `err` are broadcast to both hosts; they are only valid alongside the matching rvalid.
- Unexpected response (`mem_rvalid_i` with the queue empty):
  - The response is dropped: no host rvalid.
  - `protocol_err_o` pulses for one cycle.
  - The queue stays empty.
- Reset mid-operation: the queue is cleared, the FSM returns to `IDLE`, and the round-robin pointer goes to instr. Responses still in flight are then treated as unexpected.

## Timing
- Reset values:
  - All `*_gnt_o`, `*_rvalid_o`, `mem_req_o`, `busy_o` and `protocol_err_o` are 0.
  - Payload outputs follow their inputs combinationally (instr-selected defaults in `IDLE` with no request).
- Request to `mem_req_o`: combinational, 0 cycles. `mem_gnt_i` to host gnt: combinational.
- `mem_rvalid_i` to host rvalid: combinational. The queue head is registered state.
- Throughput: one grant per cycle while the queue is not full.
- Ordering: responses are delivered in grant order. The device is required to respond in order.

## Structure
- `ibex_pkg` gains:
  - `bus_src_e` with values `BusSrcInstr`=1'b0 and `BusSrcData`=1'b1.
  - `IbexZeroWordIntg`, the 7-bit integrity code of 32'h0.
- The arbitration FSM state type lives locally in the module.
- Sub-module `ibex_bus_arb_id_fifo`:
  - Parameterized depth, 1-bit entries.
  - Outputs `full`, `empty` and `head`, with pointers wrapping modulo `MaxOutstanding`.

## Test plan
- Both hosts request in the same cycle with `DataPriority`=1 and `mem_gnt_i`=1 → `data_gnt_o`=1 and `instr_gnt_o`=0. The next cycle grants instr. The responses route data, then instr.
- `DataPriority`=0, both hosts request continuously, `mem_gnt_i`=1 → grants alternate instr, data, instr, data. The first grant after reset goes to instr.
- Instr request with `mem_gnt_i` held low for 3 cycles while data asserts its request in cycle 1 → `mem_addr_o` stays equal to the instr address, no data grant occurs, and data is granted the cycle after the instr grant.
- `MaxOutstanding`=2, two grants, no rvalid → `mem_req_o`=0 and `busy_o`=1. One rvalid returns → the request reasserts the next cycle. `instr_rvalid_o` carries `rdata` 32'hDEADBEEF with `err`=0.
- `mem_rvalid_i` asserted with the queue empty → `protocol_err_o`=1 for one cycle and both host rvalids stay 0.
- `rst_ni` asserted with 2 transactions outstanding, then released → `busy_o`=0. A later `mem_rvalid_i` raises `protocol_err_o` and is not forwarded.

Source files
------------

// File: rtl/ibex_pkg.sv
// Shared Ibex types and constants used by the bus arbiter.
package ibex_pkg;

  // Source ID carried through the response-routing queue.
  typedef enum logic {
    BusSrcInstr = 1'b0,
    BusSrcData  = 1'b1
  } bus_src_e;

  // Inverted-SECDED (39,32) integrity code of the all-zero data word.
  parameter logic [6:0] IbexZeroWordIntg = 7'h2A;

  // The other of the two bus sources; used to advance the round-robin pointer.
  function automatic bus_src_e bus_src_other(input bus_src_e src);
    return (src == BusSrcInstr) ? BusSrcData : BusSrcInstr;
  endfunction

endpackage

// File: rtl/ibex_bus_arb_id_fifo.sv
// FIFO of 1-bit source IDs recording which host owns each in-flight transaction.
module ibex_bus_arb_id_fifo
  import ibex_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  bus_src_e push_src,
  input  logic     pop,
  output logic     full,
  output logic     empty,
  output bus_src_e head
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Depth-1:0] ids;
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic [CntW-1:0]  count;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap modulo Depth, which need not be a power of two.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    if (ptr == PtrW'(Depth - 1)) begin
      return '0;
    end
    return ptr + 1'b1;
  endfunction

  assign full    = (count == CntW'(Depth));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = bus_src_e'(ids[rd_ptr]);

  // Storage, pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ids    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        ids[wr_ptr] <= push_src;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ibex_bus_arb.sv
// Merges Ibex instruction-fetch and data ports onto one memory port with zero added latency.
module ibex_bus_arb
  import ibex_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2,
  parameter bit          DataPriority   = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic [6:0]  instr_rdata_intg_o,
  output logic        instr_err_o,

  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  input  logic [6:0]  data_wdata_intg_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic [6:0]  data_rdata_intg_o,
  output logic        data_err_o,

  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [6:0]  mem_wdata_intg_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic [6:0]  mem_rdata_intg_i,
  input  logic        mem_err_i,

  output logic        busy_o,
  output logic        protocol_err_o
);

  typedef enum logic [1:0] {
    IDLE,
    LOCK_INSTR,
    LOCK_DATA
  } arb_state_e;

  arb_state_e state_q;
  arb_state_e state_d;
  bus_src_e   rr_ptr_q;
  bus_src_e   winner;
  bus_src_e   sel;
  bus_src_e   q_head;
  logic       sel_req;
  logic       q_full;
  logic       q_empty;
  logic       push;
  logic       pop;

  // Fresh arbitration: fixed data priority or round-robin, the pointer naming the preferred source.
  always_comb begin
    winner = BusSrcInstr;
    if (instr_req_i && data_req_i) begin
      winner = DataPriority ? BusSrcData : rr_ptr_q;
    end else if (data_req_i) begin
      winner = BusSrcData;
    end
  end

  // A stalled request keeps its selection so request and payload stay stable until granted.
  always_comb begin
    case (state_q)
      LOCK_INSTR: sel = BusSrcInstr;
      LOCK_DATA:  sel = BusSrcData;
      default:    sel = winner;
    endcase
  end

  assign sel_req   = (sel == BusSrcData) ? data_req_i : instr_req_i;
  assign mem_req_o = sel_req & ~q_full;
  assign push      = mem_req_o & mem_gnt_i;
  assign pop       = mem_rvalid_i & ~q_empty;

  // State register and round-robin pointer; the pointer moves only when a grant is accepted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rr_ptr_q <= BusSrcInstr;
    end else begin
      state_q <= state_d;
      if (push) begin
        rr_ptr_q <= bus_src_other(sel);
      end
    end
  end

  // Lock on a stalled request, unlock on its grant (or if the host illegally withdraws it).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (mem_req_o && !mem_gnt_i) begin
          state_d = (sel == BusSrcData) ? LOCK_DATA : LOCK_INSTR;
        end
      end
      LOCK_INSTR: begin
        if ((mem_req_o && mem_gnt_i) || !instr_req_i) begin
          state_d = IDLE;
        end
      end
      LOCK_DATA: begin
        if ((mem_req_o && mem_gnt_i) || !data_req_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Payload mux; instruction fetches are always full-word reads of zero write data.
  always_comb begin
    mem_we_o         = 1'b0;
    mem_be_o         = 4'hF;
    mem_addr_o       = instr_addr_i;
    mem_wdata_o      = 32'h0;
    mem_wdata_intg_o = IbexZeroWordIntg;
    if (sel == BusSrcData) begin
      mem_we_o         = data_we_i;
      mem_be_o         = data_be_i;
      mem_addr_o       = data_addr_i;
      mem_wdata_o      = data_wdata_i;
      mem_wdata_intg_o = data_wdata_intg_i;
    end
  end

  assign instr_gnt_o = push & (sel == BusSrcInstr);
  assign data_gnt_o  = push & (sel == BusSrcData);

  ibex_bus_arb_id_fifo #(
    .Depth (MaxOutstanding)
  ) u_id_fifo (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .push     (push),
    .push_src (sel),
    .pop      (pop),
    .full     (q_full),
    .empty    (q_empty),
    .head     (q_head)
  );

  assign instr_rvalid_o = pop & (q_head == BusSrcInstr);
  assign data_rvalid_o  = pop & (q_head == BusSrcData);

  assign instr_rdata_o      = mem_rdata_i;
  assign instr_rdata_intg_o = mem_rdata_intg_i;
  assign instr_err_o        = mem_err_i;
  assign data_rdata_o       = mem_rdata_i;
  assign data_rdata_intg_o  = mem_rdata_intg_i;
  assign data_err_o         = mem_err_i;

  assign busy_o         = ~q_empty;
  assign protocol_err_o = mem_rvalid_i & q_empty;

endmodule

// File: tb/tb_ibex_bus_arb.sv
// Self-checking bench: index 0 is a round-robin instance, index 1 a data-priority instance.
module tb_ibex_bus_arb;
  import ibex_pkg::*;

  localparam int MaxOut = 2;
  localparam logic [6:0] ZeroIntg = 7'h2A;

  logic        clk;
  logic        rst_n;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        data_req;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [6:0]  data_wdata_intg;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [6:0]  mem_rdata_intg;
  logic        mem_err;

  logic        instr_gnt [2];
  logic        instr_rvalid [2];
  logic [31:0] instr_rdata [2];
  logic [6:0]  instr_rdata_intg [2];
  logic        instr_err [2];
  logic        data_gnt [2];
  logic        data_rvalid [2];
  logic [31:0] data_rdata [2];
  logic [6:0]  data_rdata_intg [2];
  logic        data_err [2];
  logic        mem_req [2];
  logic        mem_we [2];
  logic [3:0]  mem_be [2];
  logic [31:0] mem_addr [2];
  logic [31:0] mem_wdata [2];
  logic [6:0]  mem_wdata_intg [2];
  logic        busy [2];
  logic        perr [2];

  int checks = 0;
  int errors = 0;

  // Reference model state: in-flight owner queues, stalled selection and round-robin preference.
  int mq0[$];
  int mq1[$];
  int mlock [2];
  int mpref [2];
  int e_sel [2];
  bit e_req [2];
  bit e_ig  [2];
  bit e_dg  [2];

  typedef struct {
    logic ir, dr, gnt, rv;
    logic req;
    logic ig_pri, dg_pri, ig_rr, dg_rr;
    logic perr;
    logic addr_data_pri, addr_data_rr;
  } vec_t;
  vec_t vecs [7];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ibex_bus_arb #(.MaxOutstanding(MaxOut), .DataPriority(1'b0)) dut_rr (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_req_i(instr_req), .instr_addr_i(instr_addr),
    .instr_gnt_o(instr_gnt[0]), .instr_rvalid_o(instr_rvalid[0]), .instr_rdata_o(instr_rdata[0]),
    .instr_rdata_intg_o(instr_rdata_intg[0]), .instr_err_o(instr_err[0]),
    .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
    .data_wdata_i(data_wdata), .data_wdata_intg_i(data_wdata_intg),
    .data_gnt_o(data_gnt[0]), .data_rvalid_o(data_rvalid[0]), .data_rdata_o(data_rdata[0]),
    .data_rdata_intg_o(data_rdata_intg[0]), .data_err_o(data_err[0]),
    .mem_req_o(mem_req[0]), .mem_we_o(mem_we[0]), .mem_be_o(mem_be[0]), .mem_addr_o(mem_addr[0]),
    .mem_wdata_o(mem_wdata[0]), .mem_wdata_intg_o(mem_wdata_intg[0]),
    .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .mem_rdata_intg_i(mem_rdata_intg), .mem_err_i(mem_err),
    .busy_o(busy[0]), .protocol_err_o(perr[0])
  );

  ibex_bus_arb #(.MaxOutstanding(MaxOut), .DataPriority(1'b1)) dut_pri (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_req_i(instr_req), .instr_addr_i(instr_addr),
    .instr_gnt_o(instr_gnt[1]), .instr_rvalid_o(instr_rvalid[1]), .instr_rdata_o(instr_rdata[1]),
    .instr_rdata_intg_o(instr_rdata_intg[1]), .instr_err_o(instr_err[1]),
    .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
    .data_wdata_i(data_wdata), .data_wdata_intg_i(data_wdata_intg),
    .data_gnt_o(data_gnt[1]), .data_rvalid_o(data_rvalid[1]), .data_rdata_o(data_rdata[1]),
    .data_rdata_intg_o(data_rdata_intg[1]), .data_err_o(data_err[1]),
    .mem_req_o(mem_req[1]), .mem_we_o(mem_we[1]), .mem_be_o(mem_be[1]), .mem_addr_o(mem_addr[1]),
    .mem_wdata_o(mem_wdata[1]), .mem_wdata_intg_o(mem_wdata_intg[1]),
    .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .mem_rdata_intg_i(mem_rdata_intg), .mem_err_i(mem_err),
    .busy_o(busy[1]), .protocol_err_o(perr[1])
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic ir, input logic dr, input logic gnt, input logic rv);
    instr_req  = ir;
    data_req   = dr;
    mem_gnt    = gnt;
    mem_rvalid = rv;
    #3;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic setPayload();
    instr_addr      = 32'h0000_1000;
    data_addr       = 32'h8000_0040;
    data_we         = 1'b1;
    data_be         = 4'h3;
    data_wdata      = 32'hCAFE_0001;
    data_wdata_intg = 7'h55;
    mem_rdata       = 32'h0;
    mem_rdata_intg  = 7'h0;
    mem_err         = 1'b0;
  endtask

  task automatic resetAll();
    instr_req  = 1'b0;
    data_req   = 1'b0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    for (int p = 0; p < 2; p++) begin
      checkOutput($sformatf("rst%0d_req", p), 32'(mem_req[p]), 32'd0);
      checkOutput($sformatf("rst%0d_gnt", p), 32'({instr_gnt[p], data_gnt[p]}), 32'd0);
      checkOutput($sformatf("rst%0d_rvalid", p), 32'({instr_rvalid[p], data_rvalid[p]}), 32'd0);
      checkOutput($sformatf("rst%0d_busy", p), 32'(busy[p]), 32'd0);
      checkOutput($sformatf("rst%0d_perr", p), 32'(perr[p]), 32'd0);
    end
    mq0.delete();
    mq1.delete();
    for (int p = 0; p < 2; p++) begin
      mlock[p] = -1;
      mpref[p] = 0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    nextCycle();
  endtask

  function automatic int mSize(input int p);
    return (p == 1) ? mq1.size() : mq0.size();
  endfunction

  function automatic int mHead(input int p);
    return (p == 1) ? mq1[0] : mq0[0];
  endfunction

  function automatic int mSel(input int p);
    if (mlock[p] >= 0) return mlock[p];
    if (instr_req && data_req) return (p == 1) ? 1 : mpref[p];
    if (data_req) return 1;
    return 0;
  endfunction

  // Predict every output of instance p for the current inputs and compare.
  task automatic modelCheck(input int p, input int cyc);
    int   sel;
    int   sz;
    bit   rv_ok;
    sel   = mSel(p);
    sz    = mSize(p);
    e_sel[p] = sel;
    e_req[p] = ((sel == 1) ? data_req : instr_req) && (sz < MaxOut);
    e_ig[p]  = mem_gnt && e_req[p] && (sel == 0);
    e_dg[p]  = mem_gnt && e_req[p] && (sel == 1);
    rv_ok    = mem_rvalid && (sz > 0);
    checkOutput($sformatf("r%0d_c%0d_req", p, cyc), 32'(mem_req[p]), 32'(e_req[p]));
    checkOutput($sformatf("r%0d_c%0d_ignt", p, cyc), 32'(instr_gnt[p]), 32'(e_ig[p]));
    checkOutput($sformatf("r%0d_c%0d_dgnt", p, cyc), 32'(data_gnt[p]), 32'(e_dg[p]));
    checkOutput($sformatf("r%0d_c%0d_addr", p, cyc), mem_addr[p], (sel == 1) ? data_addr : instr_addr);
    checkOutput($sformatf("r%0d_c%0d_we", p, cyc), 32'(mem_we[p]), (sel == 1) ? 32'(data_we) : 32'd0);
    checkOutput($sformatf("r%0d_c%0d_be", p, cyc), 32'(mem_be[p]), (sel == 1) ? 32'(data_be) : 32'hF);
    checkOutput($sformatf("r%0d_c%0d_wdata", p, cyc), mem_wdata[p], (sel == 1) ? data_wdata : 32'd0);
    checkOutput($sformatf("r%0d_c%0d_wintg", p, cyc), 32'(mem_wdata_intg[p]),
                (sel == 1) ? 32'(data_wdata_intg) : 32'(ZeroIntg));
    checkOutput($sformatf("r%0d_c%0d_irv", p, cyc), 32'(instr_rvalid[p]), 32'(rv_ok && mHead(p) == 0));
    checkOutput($sformatf("r%0d_c%0d_drv", p, cyc), 32'(data_rvalid[p]), 32'(rv_ok && mHead(p) == 1));
    checkOutput($sformatf("r%0d_c%0d_perr", p, cyc), 32'(perr[p]), 32'(mem_rvalid && sz == 0));
    checkOutput($sformatf("r%0d_c%0d_busy", p, cyc), 32'(busy[p]), 32'(sz > 0));
    if (rv_ok) begin
      checkOutput($sformatf("r%0d_c%0d_rdata", p, cyc),
                  (mHead(p) == 0) ? instr_rdata[p] : data_rdata[p], mem_rdata);
      checkOutput($sformatf("r%0d_c%0d_rerr", p, cyc),
                  (mHead(p) == 0) ? 32'(instr_err[p]) : 32'(data_err[p]), 32'(mem_err));
      checkOutput($sformatf("r%0d_c%0d_rintg", p, cyc),
                  (mHead(p) == 0) ? 32'(instr_rdata_intg[p]) : 32'(data_rdata_intg[p]), 32'(mem_rdata_intg));
    end
  endtask

  // Apply the coming clock edge to the model of instance p.
  task automatic modelAdvance(input int p);
    if (mem_rvalid && mSize(p) > 0) begin
      if (p == 1) void'(mq1.pop_front());
      else        void'(mq0.pop_front());
    end
    if (e_req[p] && mem_gnt) begin
      if (p == 1) mq1.push_back(e_sel[p]);
      else        mq0.push_back(e_sel[p]);
      mlock[p] = -1;
      mpref[p] = 1 - e_sel[p];
    end else if (e_req[p]) begin
      mlock[p] = e_sel[p];
    end
  endtask

  // Protocol-compliant random hosts and device, following instance p's grants.
  task automatic runRandom(input int p, input int n);
    bit ipend;
    bit dpend;
    bit gnt;
    bit rv;
    ipend = 1'b0;
    dpend = 1'b0;
    resetAll();
    for (int cyc = 0; cyc < n; cyc++) begin
      if (!ipend && $urandom_range(0, 2) == 0) begin
        ipend      = 1'b1;
        instr_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!dpend && $urandom_range(0, 2) == 0) begin
        dpend           = 1'b1;
        data_addr       = $urandom;
        data_we         = 1'($urandom);
        data_be         = 4'($urandom);
        data_wdata      = $urandom;
        data_wdata_intg = 7'($urandom);
      end
      mem_rdata      = $urandom;
      mem_rdata_intg = 7'($urandom);
      mem_err        = 1'($urandom);
      gnt = ($urandom_range(0, 3) != 0);
      rv  = (mSize(p) > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 15) == 0);
      applyStimulus(ipend, dpend, gnt, rv);
      modelCheck(p, cyc);
      if (e_ig[p]) ipend = 1'b0;
      if (e_dg[p]) dpend = 1'b0;
      modelAdvance(p);
      nextCycle();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0;
    setPayload();
    //         ir    dr    gnt   rv    req   igP   dgP   igR   dgR   perr  adP   adR
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 7; i++) begin
      logic ad;
      resetAll();
      applyStimulus(vecs[i].ir, vecs[i].dr, vecs[i].gnt, vecs[i].rv);
      for (int p = 0; p < 2; p++) begin
        ad = (p == 1) ? vecs[i].addr_data_pri : vecs[i].addr_data_rr;
        checkOutput($sformatf("vec%0d_%0d_req", i, p), 32'(mem_req[p]), 32'(vecs[i].req));
        checkOutput($sformatf("vec%0d_%0d_ignt", i, p), 32'(instr_gnt[p]),
                    32'((p == 1) ? vecs[i].ig_pri : vecs[i].ig_rr));
        checkOutput($sformatf("vec%0d_%0d_dgnt", i, p), 32'(data_gnt[p]),
                    32'((p == 1) ? vecs[i].dg_pri : vecs[i].dg_rr));
        checkOutput($sformatf("vec%0d_%0d_perr", i, p), 32'(perr[p]), 32'(vecs[i].perr));
        checkOutput($sformatf("vec%0d_%0d_rvalid", i, p), 32'({instr_rvalid[p], data_rvalid[p]}), 32'd0);
        checkOutput($sformatf("vec%0d_%0d_addr", i, p), mem_addr[p], ad ? data_addr : instr_addr);
        checkOutput($sformatf("vec%0d_%0d_we", i, p), 32'(mem_we[p]), ad ? 32'd1 : 32'd0);
        checkOutput($sformatf("vec%0d_%0d_be", i, p), 32'(mem_be[p]), ad ? 32'h3 : 32'hF);
        checkOutput($sformatf("vec%0d_%0d_wdata", i, p), mem_wdata[p], ad ? 32'hCAFE_0001 : 32'd0);
        checkOutput($sformatf("vec%0d_%0d_wintg", i, p), 32'(mem_wdata_intg[p]),
                    ad ? 32'h55 : 32'(ZeroIntg));
      end
    end

    // Data priority: data first, instr next cycle, responses routed in grant order.
    resetAll();
    applyStimulus(1, 1, 1, 0);
    checkOutput("prio_dgnt", 32'(data_gnt[1]), 32'd1);
    checkOutput("prio_ignt", 32'(instr_gnt[1]), 32'd0);
    nextCycle();
    applyStimulus(1, 0, 1, 0);
    checkOutput("prio_ignt2", 32'(instr_gnt[1]), 32'd1);
    nextCycle();
    mem_rdata = 32'h1111_0000;
    applyStimulus(0, 0, 0, 1);
    checkOutput("prio_rsp1_drv", 32'(data_rvalid[1]), 32'd1);
    checkOutput("prio_rsp1_irv", 32'(instr_rvalid[1]), 32'd0);
    checkOutput("prio_rsp1_data", data_rdata[1], 32'h1111_0000);
    nextCycle();
    mem_rdata = 32'h2222_0000;
    applyStimulus(0, 0, 0, 1);
    checkOutput("prio_rsp2_irv", 32'(instr_rvalid[1]), 32'd1);
    checkOutput("prio_rsp2_drv", 32'(data_rvalid[1]), 32'd0);
    nextCycle();
    applyStimulus(0, 0, 0, 0);
    checkOutput("prio_idle_busy", 32'(busy[1]), 32'd0);

    // Round-robin: grants alternate starting with instr; a response each cycle keeps the queue open.
    resetAll();
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1, 1, 1, c > 0);
      checkOutput($sformatf("rr_c%0d_ignt", c), 32'(instr_gnt[0]), 32'(c % 2 == 0));
      checkOutput($sformatf("rr_c%0d_dgnt", c), 32'(data_gnt[0]), 32'(c % 2 == 1));
      if (c > 0) begin
        checkOutput($sformatf("rr_c%0d_irv", c), 32'(instr_rvalid[0]), 32'((c - 1) % 2 == 0));
      end
      nextCycle();
    end

    // Stalled instr request keeps the port locked while data waits.
    resetAll();
    instr_addr = 32'h0000_4000;
    data_addr  = 32'h8000_0100;
    for (int c = 0; c < 5; c++) begin
      applyStimulus(c < 4, c > 0, c >= 3, 0);
      for (int p = 0; p < 2; p++) begin
        checkOutput($sformatf("lock_c%0d_%0d_addr", c, p), mem_addr[p], (c < 4) ? 32'h0000_4000 : 32'h8000_0100);
        checkOutput($sformatf("lock_c%0d_%0d_ignt", c, p), 32'(instr_gnt[p]), 32'(c == 3));
        checkOutput($sformatf("lock_c%0d_%0d_dgnt", c, p), 32'(data_gnt[p]), 32'(c == 4));
      end
      nextCycle();
    end
    setPayload();

    // Full queue blocks the request, including in the cycle a response frees a slot.
    resetAll();
    for (int c = 0; c < 5; c++) begin
      if (c == 3) begin
        mem_rdata = 32'hDEAD_BEEF;
        mem_err   = 1'b0;
      end
      applyStimulus(1, 0, 1, c == 3);
      checkOutput($sformatf("full_c%0d_req", c), 32'(mem_req[1]), 32'(c < 2 || c == 4));
      checkOutput($sformatf("full_c%0d_ignt", c), 32'(instr_gnt[1]), 32'(c < 2 || c == 4));
      if (c == 2) checkOutput("full_busy", 32'(busy[1]), 32'd1);
      if (c == 3) begin
        checkOutput("full_irv", 32'(instr_rvalid[1]), 32'd1);
        checkOutput("full_rdata", instr_rdata[1], 32'hDEAD_BEEF);
        checkOutput("full_err", 32'(instr_err[1]), 32'd0);
      end
      nextCycle();
    end

    // Unexpected response with an empty queue.
    resetAll();
    applyStimulus(0, 0, 0, 1);
    checkOutput("unexp_perr", 32'(perr[1]), 32'd1);
    checkOutput("unexp_rvalid", 32'({instr_rvalid[1], data_rvalid[1]}), 32'd0);
    nextCycle();
    applyStimulus(0, 0, 0, 0);
    checkOutput("unexp_perr_off", 32'(perr[1]), 32'd0);
    checkOutput("unexp_busy", 32'(busy[1]), 32'd0);

    // Reset with two transactions outstanding; late responses become unexpected.
    resetAll();
    applyStimulus(1, 0, 1, 0);
    nextCycle();
    applyStimulus(1, 0, 1, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0);
    checkOutput("midrst_busy_before", 32'(busy[1]), 32'd1);
    resetAll();
    applyStimulus(0, 0, 0, 0);
    checkOutput("midrst_busy_after", 32'(busy[1]), 32'd0);
    nextCycle();
    applyStimulus(0, 0, 0, 1);
    checkOutput("midrst_perr", 32'(perr[1]), 32'd1);
    checkOutput("midrst_rvalid", 32'({instr_rvalid[1], data_rvalid[1]}), 32'd0);
    nextCycle();

    runRandom(1, 300);
    runRandom(0, 300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
